// File: rtl/level_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : level_fifo
//  Description : Single-clock FIFO that uses every slot. Exports fill level,
//                almost-full/almost-empty thresholds, show-ahead or registered
//                read data, a synchronous flush, and sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module level_fifo #(
    parameter int NR_OF_ENTRIES      = 16,
    parameter int BIT_WIDTH          = 32,
    parameter int ALMOST_FULL_LEVEL  = 12,
    parameter int ALMOST_EMPTY_LEVEL = 2,
    parameter int SHOW_AHEAD         = 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   clear,
    input  logic                                   push,
    input  logic                                   pop,
    input  logic [BIT_WIDTH-1:0]                   pushData,
    output logic [BIT_WIDTH-1:0]                   popData,
    output logic                                   full,
    output logic                                   empty,
    output logic                                   almostFull,
    output logic                                   almostEmpty,
    output logic [$clog2(NR_OF_ENTRIES+1)-1:0]     fillLevel,
    output logic                                   overflow,
    output logic                                   underflow
);

    localparam int              c_LW   = $clog2(NR_OF_ENTRIES + 1);
    localparam int              c_PW   = $clog2(NR_OF_ENTRIES);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(NR_OF_ENTRIES - 1);

    logic [BIT_WIDTH-1:0] r_mem [0:NR_OF_ENTRIES-1];

    logic [c_PW-1:0] r_wptr_q, w_wptr_d;
    logic [c_PW-1:0] r_rptr_q, w_rptr_d;
    logic [c_LW-1:0] r_level_q, w_level_d;
    logic            r_overflow_q, w_overflow_d;
    logic            r_underflow_q, w_underflow_d;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    always_comb begin
        w_full    = (r_level_q == c_LW'(NR_OF_ENTRIES));
        w_empty   = (r_level_q == '0);
        w_push_ok = push & (~w_full | pop);
        w_pop_ok  = pop & ~w_empty;

        w_wptr_d      = r_wptr_q;
        w_rptr_d      = r_rptr_q;
        w_level_d     = r_level_q;
        w_overflow_d  = r_overflow_q;
        w_underflow_d = r_underflow_q;

        if (clear) begin
            w_wptr_d      = '0;
            w_rptr_d      = '0;
            w_level_d     = '0;
            w_overflow_d  = 1'b0;
            w_underflow_d = 1'b0;
        end else begin
            // Pointers wrap at the last slot so non-power-of-two depths work.
            if (w_push_ok) begin
                w_wptr_d = (r_wptr_q == c_LAST) ? '0 : r_wptr_q + c_PW'(1);
            end
            if (w_pop_ok) begin
                w_rptr_d = (r_rptr_q == c_LAST) ? '0 : r_rptr_q + c_PW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                w_level_d = r_level_q + c_LW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                w_level_d = r_level_q - c_LW'(1);
            end
            if (push && !w_push_ok) begin
                w_overflow_d = 1'b1;
            end
            if (pop && !w_pop_ok) begin
                w_underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr_q      <= '0;
            r_rptr_q      <= '0;
            r_level_q     <= '0;
            r_overflow_q  <= 1'b0;
            r_underflow_q <= 1'b0;
        end else begin
            r_wptr_q      <= w_wptr_d;
            r_rptr_q      <= w_rptr_d;
            r_level_q     <= w_level_d;
            r_overflow_q  <= w_overflow_d;
            r_underflow_q <= w_underflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !clear && w_push_ok) begin
            r_mem[r_wptr_q] <= pushData;
        end
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            // Masking the head when empty keeps the output at zero after reset/flush.
            assign popData = w_empty ? '0 : r_mem[r_rptr_q];
        end else begin : g_registered
            logic [BIT_WIDTH-1:0] r_pop_data_q, w_pop_data_d;

            always_comb begin
                w_pop_data_d = r_pop_data_q;
                if (!clear && w_pop_ok) begin
                    w_pop_data_d = r_mem[r_rptr_q];
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_pop_data_q <= '0;
                end else begin
                    r_pop_data_q <= w_pop_data_d;
                end
            end

            assign popData = r_pop_data_q;
        end
    endgenerate

    assign full        = w_full;
    assign empty       = w_empty;
    assign almostFull  = (r_level_q >= c_LW'(ALMOST_FULL_LEVEL));
    assign almostEmpty = (r_level_q <= c_LW'(ALMOST_EMPTY_LEVEL));
    assign fillLevel   = r_level_q;
    assign overflow    = r_overflow_q;
    assign underflow   = r_underflow_q;

endmodule
`default_nettype wire

// File: doc/level_fifo.md
Name: level_fifo

Overview:
Parametrised successor to the team's basic synchronous FIFO. It uses all nrOfEntries slots, with no sacrificed entry. It adds an exported fill level, programmable almost-full/almost-empty thresholds, a selectable show-ahead (first-word-fall-through) or registered read mode, a synchronous flush, and sticky overflow/underflow error flags. It serves as the standard single-clock buffer between producer and consumer stages in the lab designs.

Parameters:
nrOfEntries, 16, storage depth; any integer >= 2, need not be a power of two.
bitWidth, 32, data width in bits.
almostFullLevel, 12, almostFull asserted when fillLevel >= this; range 1..nrOfEntries.
almostEmptyLevel, 2, almostEmpty asserted when fillLevel <= this; range 0..nrOfEntries-1.
showAhead, 1, 1 = first-word-fall-through read; 0 = registered read with 1-cycle latency.

Ports:
clock  input  1  single system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
clear  input  1  synchronous flush: empties the FIFO and clears the sticky flags.
push  input  1  write request.
pop  input  1  read request.
pushData  input  bitWidth  data written on an accepted push.
popData  output  bitWidth  read data; timing depends on showAhead.
full  output  1  fillLevel == nrOfEntries.
empty  output  1  fillLevel == 0.
almostFull  output  1  fillLevel >= almostFullLevel.
almostEmpty  output  1  fillLevel <= almostEmptyLevel.
fillLevel  output  $clog2(nrOfEntries+1)  number of stored entries.
overflow  output  1  sticky: a push was rejected because the FIFO was full.
underflow  output  1  sticky: a pop was rejected because the FIFO was empty.

Behaviour:
- Reset (synchronous, active-high) values:
  - fillLevel=0, empty=1, full=0, almostEmpty=1, almostFull=0.
  - overflow=0, underflow=0, popData=0.
  - Read and write pointers = 0.
- Priority per edge: reset > clear > push/pop.
  - clear gives the same result as reset, except that popData holds its value in showAhead=0 mode.
  - Stored contents are discarded; no push or pop is accepted in that cycle.
- Accept rules, evaluated on pre-edge state:
  - pushOk = push & (~full | pop).
  - popOk = pop & ~empty.
  - Full with push and pop together: both are accepted and fillLevel is unchanged.
  - Empty with push and pop together: the push is accepted, the pop is rejected and underflow is set. No bypass.
- Rejected requests:
  - A rejected push sets overflow; a rejected pop sets underflow.
  - Neither changes pointers, contents or fillLevel.
  - overflow/underflow stay set until reset or clear.
- Pointers: write and read pointers range 0..nrOfEntries-1 and wrap explicitly from nrOfEntries-1 to 0. Modulo-2^n wrap is not permitted.
- fillLevel: registered.
  - +1 on pushOk & ~popOk; -1 on popOk & ~pushOk; otherwise unchanged.
  - All status flags are decoded from the registered fillLevel, so they change at the same edge as fillLevel.
- Write latency: a push accepted at edge N gives empty=0 and fillLevel=1 after edge N, for a FIFO that was empty.
- showAhead=1:
  - popData equals the head entry whenever empty=0; it is undefined-but-stable when empty.
  - Data pushed at edge N appears on popData in cycle N+1.
  - A pop at edge M advances popData to the next entry after edge M.
- showAhead=0:
  - popData is a register loaded at the edge where popOk=1, with the entry being removed.
  - It holds at all other times.
  - Latency from pop to data is one cycle.
- Back-to-back throughput: one push and one pop per cycle sustained, at any fill level.

Test Plan:
- Reset/idle: assert reset for 2 cycles with push=1 -> fillLevel=0, empty=1, almostEmpty=1, overflow=0, popData=0; no entry stored.
- Fill and overflow (defaults): push 0x0..0xF on 16 consecutive cycles, then push 0xAA -> full=1 after the 16th push, almostFull from the 12th push, fillLevel=16; 0xAA rejected, overflow=1 and sticky.
- Drain order with showAhead=1: from the full state, pop 16 times -> popData sequence 0x0..0xF, with each value visible before its pop. Then pop once more -> underflow=1, empty=1, fillLevel=0.
- Simultaneous push/pop: while full, push 0x55 with pop -> fillLevel stays 16, head advances, 0x55 becomes the last entry. While empty, push+pop -> fillLevel=1, underflow=1.
- Registered mode (showAhead=0, nrOfEntries=5): push 1,2,3, then pop each cycle -> popData = 1, 2, 3 one cycle after each pop. Then push 7 entries across the wrap, interleaved with pops -> correct order, exercising the non-power-of-two wrap.
- Clear mid-operation: with fillLevel=9 and overflow=1, assert clear together with push and pop -> next cycle fillLevel=0, empty=1, overflow=0; the push is not stored.
